// File: rtl/spi_pkg.sv
// Shared definitions for the TRSQ8 SPI slave: register offsets, SPSCON bit
// positions and the frame FSM state encoding.
package spi_pkg;

    localparam logic [1:0] REG_SPSCON = 2'd0;
    localparam logic [1:0] REG_SPSTX  = 2'd1;
    localparam logic [1:0] REG_SPSRX  = 2'd2;
    localparam logic [1:0] REG_SPSCNT = 2'd3;

    localparam int unsigned CON_TX_READY = 7;
    localparam int unsigned CON_OVERRUN  = 6;
    localparam int unsigned CON_RX_FULL  = 5;
    localparam int unsigned CON_ENABLE   = 4;
    localparam int unsigned CON_RX_IE    = 3;
    localparam int unsigned CON_CPHA     = 2;
    localparam int unsigned CON_CPOL     = 1;
    localparam int unsigned CON_BUSY     = 0;

    // Byte shifted out when the CPU has not refilled SPSTX.
    localparam logic [7:0] TX_UNDERRUN = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/spi_slave_sync.sv
// Pin conditioning for the SPI slave: 2-FF synchronizers on sclk/mosi/ss_n
// followed by an edge register; all outputs are aligned and registered.
module spi_slave_sync (
    input  logic clk,
    input  logic reset,
    input  logic sclk,
    input  logic mosi,
    input  logic ss_n,
    output logic mosi_s,
    output logic ss_n_s,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic ss_fall,
    output logic ss_rise
);

    logic [1:0] sclk_q;
    logic [1:0] mosi_q;
    logic [1:0] ss_q;
    logic       sclk_d;

    // ss_n resets low so a frame already in progress at reset is never seen as a fall.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_q    <= 2'b00;
            mosi_q    <= 2'b00;
            ss_q      <= 2'b00;
            sclk_d    <= 1'b0;
            mosi_s    <= 1'b0;
            ss_n_s    <= 1'b0;
            sclk_rise <= 1'b0;
            sclk_fall <= 1'b0;
            ss_fall   <= 1'b0;
            ss_rise   <= 1'b0;
        end else begin
            sclk_q    <= {sclk_q[0], sclk};
            mosi_q    <= {mosi_q[0], mosi};
            ss_q      <= {ss_q[0], ss_n};
            sclk_d    <= sclk_q[1];
            mosi_s    <= mosi_q[1];
            ss_n_s    <= ss_q[1];
            sclk_rise <= sclk_q[1] & ~sclk_d;
            sclk_fall <= ~sclk_q[1] & sclk_d;
            ss_fall   <= ~ss_q[1] & ss_n_s;
            ss_rise   <= ss_q[1] & ~ss_n_s;
        end
    end

endmodule

// File: rtl/spi_slave_top.sv
// SPI slave peripheral on the TRSQ8 8-bit MMIO bus (SPSCON/SPSTX/SPSRX/SPSCNT).
// Define SPI_SLAVE_IRQ_EN to add the irq output and the SPSCON.rx_ie bit.
module spi_slave_top
    import spi_pkg::*;
#(
    parameter int unsigned ADDR_LSB          = 0,
    parameter int unsigned OPT_MEM_ADDR_BITS = 1,
    parameter logic [7:0]  BASE_ADDR         = 8'h90
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
`ifdef SPI_SLAVE_IRQ_EN
    output logic       irq,
`endif
    input  logic       wr_en,
    input  logic       rd_en,
    input  logic       sclk,
    input  logic       mosi,
    input  logic       ss_n,
    output logic       miso
);

    localparam int unsigned LOC_W  = OPT_MEM_ADDR_BITS + 1;
    localparam int unsigned LOC_HI = ADDR_LSB + OPT_MEM_ADDR_BITS;

    logic [LOC_W-1:0] loc_addr;
    logic sel_con, sel_tx, sel_rx, sel_cnt, rd_go;

    logic mosi_s, ss_n_s, sclk_rise, sclk_fall, ss_fall, ss_rise;

    state_t     state;
    logic       tx_ready, overrun, rx_full, enable, cpha, cpol, rx_ie, busy;
    logic [7:0] tx_buf, rx_buf, frame_cnt, tx_shift, rx_shift, con_rd;
    logic [2:0] bit_cnt;

    logic lead_edge, trail_edge, sample_edge, shift_edge, stop_frame, load_go;
    logic unused_addr;

    assign loc_addr = addr[LOC_HI:ADDR_LSB];
    assign sel_con  = (loc_addr == LOC_W'(REG_SPSCON));
    assign sel_tx   = (loc_addr == LOC_W'(REG_SPSTX));
    assign sel_rx   = (loc_addr == LOC_W'(REG_SPSRX));
    assign sel_cnt  = (loc_addr == LOC_W'(REG_SPSCNT));
    assign rd_go    = rd_en & ~wr_en;

    // Window hit against BASE_ADDR is kept for debug only; decoding is external.
    assign unused_addr = ^{addr, (addr[7:LOC_HI+1] == BASE_ADDR[7:LOC_HI+1])};

    spi_slave_sync u_sync (
        .clk       (clk),
        .reset     (reset),
        .sclk      (sclk),
        .mosi      (mosi),
        .ss_n      (ss_n),
        .mosi_s    (mosi_s),
        .ss_n_s    (ss_n_s),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .ss_fall   (ss_fall),
        .ss_rise   (ss_rise)
    );

    // Leading edge leaves the cpol idle level; the first leading edge in cpha=1
    // must not shift because LOAD already put the MSB on miso.
    assign lead_edge   = cpol ? sclk_fall : sclk_rise;
    assign trail_edge  = cpol ? sclk_rise : sclk_fall;
    assign sample_edge = cpha ? trail_edge : lead_edge;
    assign shift_edge  = (cpha ? lead_edge : trail_edge) && (bit_cnt != 3'd0);
    assign stop_frame  = ss_n_s | ss_rise | ~enable;
    assign busy        = (state != ST_IDLE);

    // Loading happens on entry to LOAD so back-to-back MSBs reach miso quickly.
    assign load_go = ((state == ST_IDLE) && ss_fall && enable) ||
                     ((state == ST_DONE) && !stop_frame);

    always_comb begin
        con_rd               = 8'h00;
        con_rd[CON_TX_READY] = tx_ready;
        con_rd[CON_OVERRUN]  = overrun;
        con_rd[CON_RX_FULL]  = rx_full;
        con_rd[CON_ENABLE]   = enable;
        con_rd[CON_RX_IE]    = rx_ie;
        con_rd[CON_CPHA]     = cpha;
        con_rd[CON_CPOL]     = cpol;
        con_rd[CON_BUSY]     = busy;
    end

    // Statement order sets same-cycle priority: hardware overrun/rx_full wins
    // over software, SPSTX write wins over LOAD, SPSCNT clear wins over count.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            dout      <= 8'h00;
            miso      <= 1'b0;
            tx_ready  <= 1'b1;
            overrun   <= 1'b0;
            rx_full   <= 1'b0;
            enable    <= 1'b0;
            cpha      <= 1'b0;
            cpol      <= 1'b0;
            tx_buf    <= 8'h00;
            rx_buf    <= 8'h00;
            frame_cnt <= 8'h00;
            tx_shift  <= 8'h00;
            rx_shift  <= 8'h00;
            bit_cnt   <= 3'd0;
        end else begin
            if (rd_go) begin
                if (sel_con)      dout <= con_rd;
                else if (sel_tx)  dout <= tx_buf;
                else if (sel_rx)  dout <= rx_buf;
                else if (sel_cnt) dout <= frame_cnt;
                if (sel_rx) rx_full <= 1'b0;
            end

            if (wr_en && sel_con) begin
                if (din[CON_OVERRUN]) overrun <= 1'b0;
                enable <= din[CON_ENABLE];
                cpha   <= din[CON_CPHA];
                cpol   <= din[CON_CPOL];
            end

            case (state)
                ST_IDLE: miso <= 1'b0;
                ST_LOAD: state <= ST_SHIFT;
                ST_SHIFT: begin
                    if (sample_edge) begin
                        rx_shift <= {rx_shift[6:0], mosi_s};
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= ST_DONE;
                    end
                    if (shift_edge) begin
                        tx_shift <= {tx_shift[6:0], 1'b0};
                        miso     <= tx_shift[6];
                    end
                end
                ST_DONE: begin
                    if (rx_full) overrun <= 1'b1;
                    else         rx_buf  <= rx_shift;
                    rx_full   <= 1'b1;
                    frame_cnt <= frame_cnt + 8'd1;
                    state     <= ST_IDLE;
                    miso      <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase

            // Partial byte is dropped; the TX byte already loaded stays consumed.
            if (((state == ST_LOAD) || (state == ST_SHIFT)) && stop_frame) begin
                state <= ST_IDLE;
                miso  <= 1'b0;
            end

            if (load_go) begin
                state    <= ST_LOAD;
                tx_shift <= tx_ready ? TX_UNDERRUN : tx_buf;
                miso     <= tx_ready ? TX_UNDERRUN[7] : tx_buf[7];
                tx_ready <= 1'b1;
                bit_cnt  <= 3'd0;
            end

            if (wr_en && sel_tx) begin
                tx_buf   <= din;
                tx_ready <= 1'b0;
            end

            if (wr_en && sel_cnt) frame_cnt <= 8'h00;
        end
    end

`ifdef SPI_SLAVE_IRQ_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_ie <= 1'b0;
            irq   <= 1'b0;
        end else begin
            if (wr_en && sel_con) rx_ie <= din[CON_RX_IE];
            irq <= rx_ie & (rx_full | overrun);
        end
    end
`else
    assign rx_ie = 1'b0;
`endif

endmodule
